// File: rtl/membrane_integrator_if.sv
// Ionic-current bundle between the current/gating blocks (producer) and the
// membrane integrator (consumer), plus the membrane-potential feedback path.
//
// Handshake: a current set transfers on a rising clk edge where i_valid and
// i_ready are both 1. The consumer raises i_ready only when it can take a new
// set; i_valid seen while i_ready is 0 is ignored and nothing is captured.
// v_valid is a one-cycle pulse marking a freshly updated v. It has no ready
// and cannot be back-pressured.
interface membrane_integrator_if #(
    parameter int DW = 16
);
    logic signed [DW-1:0] i_ext;
    logic signed [DW-1:0] i_na;
    logic signed [DW-1:0] i_k;
    logic signed [DW-1:0] i_l;
    logic                 i_valid;
    logic                 i_ready;
    logic signed [DW-1:0] v;
    logic                 v_valid;
    logic                 spike;
    logic [15:0]          spike_count;

    // Producer side: current/gating blocks drive currents, observe V.
    modport master (
        output i_ext, i_na, i_k, i_l, i_valid,
        input  i_ready, v, v_valid, spike, spike_count
    );

    // Consumer side: the integrator.
    modport slave (
        input  i_ext, i_na, i_k, i_l, i_valid,
        output i_ready, v, v_valid, spike, spike_count
    );
endinterface

// File: rtl/membrane_integrator.sv
// Membrane integrator: forward-Euler update of membrane potential V from the
// per-step ionic currents, V' = V + (dt/Cm) * (I_ext - I_na - I_k - I_l),
// all in signed Q8.8. One step takes four cycles (IDLE, SUM, SCALE, UPDATE).
// The result is clamped to [V_MIN, V_MAX], and upward crossings of V_THRESH
// are flagged as spikes and counted with a saturating counter.
module membrane_integrator #(
    parameter int DW        = 16,
    parameter int FRAC      = 8,
    parameter int V_REST    = -16640,
    parameter int DT_OVER_C = 64,
    parameter int V_THRESH  = 0,
    parameter int V_MAX     = 15360,
    parameter int V_MIN     = -25600
) (
    input  logic                  clk,
    input  logic                  rst,
    membrane_integrator_if.slave  bus,
    output logic [1:0]            fsm_state
);

    // Sum width: four DW-bit terms cannot overflow DW+2 bits.
    localparam int SW = DW + 2;
    // Product width: the sum times a DW-bit gain. v_next is also computed at
    // this width, so neither the product nor the addition can wrap before
    // the clamp is applied.
    localparam int PW = SW + DW;

    localparam logic signed [DW-1:0] REST_W   = DW'(V_REST);
    localparam logic signed [DW-1:0] THRESH_W = DW'(V_THRESH);
    localparam logic signed [PW-1:0] MAX_W    = PW'(V_MAX);
    localparam logic signed [PW-1:0] MIN_W    = PW'(V_MIN);
    localparam logic signed [PW-1:0] GAIN_W   = PW'(DT_OVER_C);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUM    = 2'd1,
        SCALE  = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t state;

    // Captured current set. The producer may change its inputs after the
    // accept edge, so every later stage works from these copies.
    logic signed [DW-1:0] cap_ext;
    logic signed [DW-1:0] cap_na;
    logic signed [DW-1:0] cap_k;
    logic signed [DW-1:0] cap_l;

    logic signed [SW-1:0] sum_r;
    logic signed [PW-1:0] delta_r;

    logic signed [DW-1:0] v_r;
    logic                 v_valid_r;
    logic                 spike_r;
    logic [15:0]          count_r;
    logic                 ready_r;

    // Datapath intermediates, one per pipeline stage.
    logic signed [SW-1:0] sum_next;
    logic signed [PW-1:0] prod_next;
    logic signed [PW-1:0] delta_next;
    logic signed [PW-1:0] v_wide;
    logic signed [DW-1:0] v_clamped;
    logic                 crossing;

    // Net membrane current. Each term is sign-extended to SW bits first, so
    // the three subtractions are exact.
    always_comb begin
        sum_next = SW'(cap_ext) - SW'(cap_na) - SW'(cap_k) - SW'(cap_l);
    end

    // Scale by dt/Cm. The arithmetic shift floors toward minus infinity. A
    // small negative net current therefore still moves V down by one LSB,
    // and a small positive one moves it by nothing.
    always_comb begin
        prod_next  = PW'(sum_r) * GAIN_W;
        delta_next = prod_next >>> FRAC;
    end

    // Integrate and clamp. A value sitting at a bound stays there instead of
    // wrapping, because the addition is done at full width before clamping.
    always_comb begin
        v_wide = PW'(v_r) + delta_r;
        if (v_wide > MAX_W) begin
            v_clamped = DW'(MAX_W);
        end else if (v_wide < MIN_W) begin
            v_clamped = DW'(MIN_W);
        end else begin
            v_clamped = DW'(v_wide);
        end
        // A spike is an upward crossing only. The check uses the clamped
        // value, so landing exactly on V_MAX from below still counts.
        crossing = (v_r < THRESH_W) && (v_clamped >= THRESH_W);
    end

    // Step sequencer. State, datapath registers and all outputs are updated
    // here, so every output is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cap_ext   <= '0;
            cap_na    <= '0;
            cap_k     <= '0;
            cap_l     <= '0;
            sum_r     <= '0;
            delta_r   <= '0;
            v_r       <= REST_W;
            v_valid_r <= 1'b0;
            spike_r   <= 1'b0;
            count_r   <= '0;
            ready_r   <= 1'b1;
        end else begin
            // Single-cycle pulses. They default low and are set only in
            // UPDATE.
            v_valid_r <= 1'b0;
            spike_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_valid && ready_r) begin
                        cap_ext <= bus.i_ext;
                        cap_na  <= bus.i_na;
                        cap_k   <= bus.i_k;
                        cap_l   <= bus.i_l;
                        ready_r <= 1'b0;
                        state   <= SUM;
                    end
                end
                SUM: begin
                    sum_r <= sum_next;
                    state <= SCALE;
                end
                SCALE: begin
                    delta_r <= delta_next;
                    state   <= UPDATE;
                end
                UPDATE: begin
                    v_r       <= v_clamped;
                    v_valid_r <= 1'b1;
                    spike_r   <= crossing;
                    if (crossing && (count_r != 16'hFFFF)) begin
                        count_r <= count_r + 16'd1;
                    end
                    // i_ready rises on the same edge that raises v_valid.
                    // This lets the next set be accepted one edge later,
                    // which gives one step every four cycles.
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.i_ready     = ready_r;
    assign bus.v           = v_r;
    assign bus.v_valid     = v_valid_r;
    assign bus.spike       = spike_r;
    assign bus.spike_count = count_r;
    assign fsm_state       = state;

endmodule
